pmt_count_buffer: RTL and testbench

- Sits directly downstream of the laser sequencer and consumes its PMT count pulses (count-ready strobe + 32-bit count) and per-count laser-lock error flags.
- Buffers readings in a FIFO.
- When the sequencer raises its send-data request, streams all buffered readings as one framed byte packet to the PC-link byte transmitter.
- Then raises the finished-sending handshake the sequencer waits on before it advances.

---
 rtl/pmt_count_buffer_if.sv | 27 ++
 rtl/pmt_count_buffer.sv | 190 +++++++++++++++++++
 tb/tb_pmt_count_buffer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmt_count_buffer_if.sv
// Signal bundle between the laser sequencer / PC-link transmitter and pmt_count_buffer.
// The slave modport is the buffer's view; master is the sequencer/transmitter side.
interface pmt_count_buffer_if #(
    parameter int DEPTH_LOG2 = 6
);
    logic                  iCountReady;
    logic [31:0]           iCountData;
    logic [3:0]            iErrorSignal;
    logic                  iSendData;
    logic                  iFlush;
    logic                  oFinishedSendingData;
    logic [7:0]            oTxData;
    logic                  oTxValid;
    logic                  iTxReady;
    logic                  oOverflow;
    logic [DEPTH_LOG2:0]   oFillLevel;

    modport slave (
        input  iCountReady, iCountData, iErrorSignal, iSendData, iFlush, iTxReady,
        output oFinishedSendingData, oTxData, oTxValid, oOverflow, oFillLevel
    );

    modport master (
        output iCountReady, iCountData, iErrorSignal, iSendData, iFlush, iTxReady,
        input  oFinishedSendingData, oTxData, oTxValid, oOverflow, oFillLevel
    );
endinterface

// File: rtl/pmt_count_buffer.sv
// Buffers PMT count readings in a FIFO and streams them as one framed byte packet
// (header, length, 3 bytes per reading, trailer) when the sequencer requests a send.
module pmt_count_buffer #(
    parameter int DEPTH_LOG2 = 6,
    parameter int COUNT_BITS = 20
) (
    input logic              iCLOCK,
    input logic              iRESET,
    pmt_count_buffer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [7:0] HDR_OK  = 8'hA5;
    localparam logic [7:0] HDR_OVF = 8'hA6;
    localparam logic [7:0] TRAILER = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LEN, S_DATA, S_TRL, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [23:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
    logic [DEPTH_LOG2:0]   count_q, count_d, len_q, len_d, left_q, left_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  ovf_q, ovf_d;

    logic [19:0]           sat_count;
    logic [23:0]           entry_in, head, next_head;
    logic                  full, accept, pop, push, flush;

    function automatic logic [7:0] entry_byte(input logic [23:0] e, input logic [1:0] idx);
        case (idx)
            2'd0:    return e[23:16];
            2'd1:    return e[15:8];
            default: return e[7:0];
        endcase
    endfunction

    // Counts that do not fit in COUNT_BITS clamp to all-ones rather than wrapping.
    always_comb begin
        sat_count = 20'(iCountData_w());
        if ((bus.iCountData >> COUNT_BITS) != 32'd0)
            sat_count = 20'((64'd1 << COUNT_BITS) - 64'd1);
    end

    function automatic logic [31:0] iCountData_w();
        return bus.iCountData;
    endfunction

    assign entry_in   = {bus.iErrorSignal, sat_count};
    assign rd_ptr_nxt = rd_ptr_q + DEPTH_LOG2'(1);
    assign head       = mem_q[rd_ptr_q];
    assign next_head  = mem_q[rd_ptr_nxt];
    assign full       = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign accept     = tx_valid_q & bus.iTxReady;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        len_d      = len_q;
        left_d     = left_q;
        byte_idx_d = byte_idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        pop        = 1'b0;
        flush      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.iFlush) begin
                    flush = 1'b1;
                end else if (bus.iSendData) begin
                    len_d      = count_q;
                    left_d     = count_q;
                    state_d    = S_HDR;
                    tx_valid_d = 1'b1;
                    tx_data_d  = ovf_q ? HDR_OVF : HDR_OK;
                end
            end
            S_HDR: begin
                if (accept) begin
                    state_d   = S_LEN;
                    tx_data_d = 8'(len_q);
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (len_q != '0) begin
                        state_d    = S_DATA;
                        byte_idx_d = 2'd0;
                        tx_data_d  = head[23:16];
                    end else begin
                        state_d    = S_TRL;
                        tx_data_d  = TRAILER;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (byte_idx_q != 2'd2) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_data_d  = entry_byte(head, byte_idx_q + 2'd1);
                    end else begin
                        // Entry leaves the FIFO only once its last byte is taken.
                        pop        = 1'b1;
                        left_d     = left_q - 1'b1;
                        byte_idx_d = 2'd0;
                        if (left_q == (DEPTH_LOG2+1)'(1)) begin
                            state_d   = S_TRL;
                            tx_data_d = TRAILER;
                        end else begin
                            tx_data_d = next_head[23:16];
                        end
                    end
                end
            end
            S_TRL: begin
                if (accept) begin
                    state_d    = S_DONE;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                end
            end
            S_DONE: begin
                if (!bus.iSendData)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A write while full is still taken when a pop frees a slot on the same edge.
        push     = bus.iCountReady & ~flush & (~full | pop);
        wr_ptr_d = flush ? '0 : (push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q);
        rd_ptr_d = flush ? '0 : (pop  ? rd_ptr_nxt : rd_ptr_q);

        count_d = count_q;
        if (flush)
            count_d = '0;
        else if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;

        ovf_d = ovf_q;
        if (flush)
            ovf_d = 1'b0;
        else if (bus.iCountReady && full && !pop)
            ovf_d = 1'b1;
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            len_q      <= '0;
            left_q     <= '0;
            byte_idx_q <= 2'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            len_q      <= len_d;
            left_q     <= left_d;
            byte_idx_q <= byte_idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge iCLOCK) begin
        if (push)
            mem_q[wr_ptr_q] <= entry_in;
    end

    assign bus.oTxData              = tx_data_q;
    assign bus.oTxValid             = tx_valid_q;
    assign bus.oOverflow            = ovf_q;
    assign bus.oFillLevel           = count_q;
    assign bus.oFinishedSendingData = (state_q == S_DONE);
endmodule

// File: tb/tb_pmt_count_buffer.sv
// Self-checking bench for pmt_count_buffer: a queue-based packet model predicts
// every transmitted byte, the fill level, overflow and the finished handshake.
module tb_pmt_count_buffer;
    localparam int DEPTH_LOG2 = 6;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic iCLOCK = 1'b0;
    logic iRESET = 1'b1;
    always #5 iCLOCK = ~iCLOCK;

    pmt_count_buffer_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    pmt_count_buffer #(.DEPTH_LOG2(DEPTH_LOG2), .COUNT_BITS(20)) dut (
        .iCLOCK (iCLOCK),
        .iRESET (iRESET),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: FIFO contents as a queue, packet as a list of expected bytes.
    typedef enum int {M_IDLE, M_SEND, M_DONE} mphase_t;
    mphase_t     mph  = M_IDLE;
    logic [23:0] mq[$];
    bit          movf = 1'b0;
    logic [7:0]  exp_b[$];
    logic [7:0]  got[$];
    int          bidx = 0;
    bit          held = 1'b0;
    logic [7:0]  held_data = 8'h00;

    function automatic logic [23:0] model_entry(input logic [31:0] d, input logic [3:0] e);
        return {e, (d > 32'h000F_FFFF) ? 20'hFFFFF : d[19:0]};
    endfunction

    // Samples just before each rising edge: compares the current outputs, then
    // advances the model by what the coming edge will do.
    always begin
        mphase_t ph0;
        bit      accept, pop;
        @(negedge iCLOCK);
        #4;
        check("fill", bus.oFillLevel, mq.size());
        check("overflow", bus.oOverflow, movf);
        check("finished", bus.oFinishedSendingData, mph == M_DONE);
        if (mph != M_SEND) check("valid_idle", bus.oTxValid, 1'b0);
        if (held) begin
            check("hold_valid", bus.oTxValid, 1'b1);
            check("hold_data", bus.oTxData, held_data);
        end
        held      = bus.oTxValid && !bus.iTxReady;
        held_data = bus.oTxData;

        if (iRESET) begin
            mq.delete();
            movf = 1'b0;
            mph  = M_IDLE;
            held = 1'b0;
        end else begin
            ph0    = mph;
            accept = bus.oTxValid && bus.iTxReady;
            pop    = 1'b0;
            if (accept && ph0 == M_SEND) begin
                got.push_back(bus.oTxData);
                check("byte", bus.oTxData, exp_b[bidx]);
                if (bidx >= 2 && bidx < exp_b.size() - 1 && (bidx - 2) % 3 == 2) pop = 1'b1;
                bidx++;
                if (bidx == exp_b.size()) mph = M_DONE;
            end
            if (ph0 == M_IDLE) begin
                if (bus.iFlush) begin
                    mq.delete();
                    movf = 1'b0;
                end else if (bus.iSendData) begin
                    exp_b.delete();
                    got.delete();
                    exp_b.push_back(movf ? 8'hA6 : 8'hA5);
                    exp_b.push_back(8'(mq.size()));
                    foreach (mq[i]) begin
                        exp_b.push_back(mq[i][23:16]);
                        exp_b.push_back(mq[i][15:8]);
                        exp_b.push_back(mq[i][7:0]);
                    end
                    exp_b.push_back(8'h5A);
                    bidx = 0;
                    mph  = M_SEND;
                end
            end else if (ph0 == M_DONE && !bus.iSendData) begin
                mph = M_IDLE;
            end
            if (pop) void'(mq.pop_front());
            if (bus.iCountReady && !(ph0 == M_IDLE && bus.iFlush)) begin
                if (mq.size() < DEPTH) mq.push_back(model_entry(bus.iCountData, bus.iErrorSignal));
                else movf = 1'b1;
            end
        end
    end

    task automatic do_reset();
        @(negedge iCLOCK);
        iRESET               = 1'b1;
        bus.iCountReady      = 1'b0;
        bus.iSendData        = 1'b0;
        bus.iFlush           = 1'b0;
        bus.iTxReady         = 1'b1;
        @(negedge iCLOCK);
        iRESET = 1'b0;
    endtask

    task automatic write_reading(input logic [31:0] d, input logic [3:0] e);
        @(negedge iCLOCK);
        bus.iCountReady  = 1'b1;
        bus.iCountData   = d;
        bus.iErrorSignal = e;
        @(negedge iCLOCK);
        bus.iCountReady  = 1'b0;
    endtask

    task automatic write_random();
        logic [31:0] d;
        d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h000F_FFFF));
        write_reading(d, 4'($urandom_range(0, 15)));
    endtask

    task automatic send_packet(input bit rand_ready, input int inject, input int exp_len, input string tag);
        int cyc = 0;
        int injected = 0;
        @(negedge iCLOCK);
        bus.iSendData = 1'b1;
        bus.iTxReady  = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        while (!bus.oFinishedSendingData && cyc < 5000) begin
            @(negedge iCLOCK);
            cyc++;
            bus.iCountReady = 1'b0;
            bus.iTxReady    = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (injected < inject && got.size() >= 5 + 4 * injected && bus.oTxValid) begin
                bus.iCountReady  = 1'b1;
                bus.iCountData   = $urandom;
                bus.iErrorSignal = 4'($urandom_range(0, 15));
                injected++;
            end
        end
        bus.iCountReady = 1'b0;
        bus.iTxReady    = 1'b1;
        check({tag, "_in_time"}, cyc < 5000, 1'b1);
        check({tag, "_len"}, got.size(), exp_len);
        @(negedge iCLOCK);
        check({tag, "_fin_held"}, bus.oFinishedSendingData, 1'b1);
        bus.iSendData = 1'b0;
        #1 check({tag, "_fin_before_drop"}, bus.oFinishedSendingData, 1'b1);
        @(negedge iCLOCK);
        check({tag, "_fin_dropped"}, bus.oFinishedSendingData, 1'b0);
    endtask

    logic [7:0] t1_bytes [12] = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h05, 8'h31,
                                  8'h23, 8'h45, 8'h0F, 8'hFF, 8'hFF, 8'h5A};
    logic [7:0] empty_bytes [3] = '{8'hA5, 8'h00, 8'h5A};

    task automatic check_empty_packet(input string tag);
        send_packet(1'b0, 0, 3, tag);
        for (int i = 0; i < 3 && i < got.size(); i++) check({tag, "_byte"}, got[i], empty_bytes[i]);
        check({tag, "_fill"}, bus.oFillLevel, 0);
    endtask

    initial begin
        bus.iCountReady  = 1'b0;
        bus.iCountData   = '0;
        bus.iErrorSignal = '0;
        bus.iSendData    = 1'b0;
        bus.iFlush       = 1'b0;
        bus.iTxReady     = 1'b1;

        // Reset state.
        do_reset();
        check("rst_fill", bus.oFillLevel, 0);
        check("rst_valid", bus.oTxValid, 1'b0);
        check("rst_data", bus.oTxData, 8'h00);
        check("rst_ovf", bus.oOverflow, 1'b0);
        check("rst_fin", bus.oFinishedSendingData, 1'b0);

        // Three known readings, including one that saturates.
        write_reading(32'h0000_0005, 4'h0);
        write_reading(32'h0001_2345, 4'h3);
        write_reading(32'h0010_0000, 4'h0);
        send_packet(1'b0, 0, 12, "t1");
        for (int i = 0; i < 12 && i < got.size(); i++) check("t1_byte", got[i], t1_bytes[i]);

        // Empty buffer.
        check_empty_packet("empty");

        // Fill to capacity, then one more reading is dropped.
        do_reset();
        for (int i = 0; i < DEPTH; i++) write_random();
        check("full_fill", bus.oFillLevel, DEPTH);
        check("full_ovf_clear", bus.oOverflow, 1'b0);
        write_random();
        check("ovf_set", bus.oOverflow, 1'b1);
        check("ovf_fill", bus.oFillLevel, DEPTH);
        send_packet(1'b0, 0, 3 + 3 * DEPTH, "ovf");
        if (got.size() >= 2) begin
            check("ovf_hdr", got[0], 8'hA6);
            check("ovf_len", got[1], 8'h40);
        end
        check("ovf_sticky", bus.oOverflow, 1'b1);

        // Random back-pressure with readings arriving mid-packet.
        do_reset();
        for (int i = 0; i < 6; i++) write_random();
        send_packet(1'b1, 2, 21, "bp");
        check("bp_fill_after", bus.oFillLevel, 2);
        for (int r = 0; r < 4; r++) begin
            int n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) write_random();
            send_packet(1'b1, $urandom_range(0, 2), 3 + 3 * mq.size(), "rnd");
        end

        // Reset in the middle of the data phase.
        do_reset();
        for (int i = 0; i < 4; i++) write_random();
        begin
            int cyc = 0;
            @(negedge iCLOCK);
            bus.iSendData = 1'b1;
            bus.iTxReady  = 1'b1;
            while (got.size() < 4 && cyc < 100) begin
                @(negedge iCLOCK);
                cyc++;
            end
            check("mid_reach_data", cyc < 100, 1'b1);
            iRESET        = 1'b1;
            bus.iSendData = 1'b0;
            @(negedge iCLOCK);
            check("mid_valid", bus.oTxValid, 1'b0);
            check("mid_fill", bus.oFillLevel, 0);
            check("mid_fin", bus.oFinishedSendingData, 1'b0);
            iRESET = 1'b0;
        end
        check_empty_packet("post_rst");

        // Flush together with send in IDLE: first with overflow set, then with 5 entries.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) write_random();
        for (int k = 0; k < 2; k++) begin
            if (k == 1) for (int i = 0; i < 5; i++) write_random();
            @(negedge iCLOCK);
            bus.iFlush    = 1'b1;
            bus.iSendData = 1'b1;
            @(negedge iCLOCK);
            bus.iFlush    = 1'b0;
            bus.iSendData = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge iCLOCK);
                check("flush_no_pkt", bus.oTxValid, 1'b0);
            end
            check("flush_fill", bus.oFillLevel, 0);
            check("flush_ovf", bus.oOverflow, 1'b0);
        end
        check_empty_packet("post_flush");

        repeat (3) @(negedge iCLOCK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
